um245r_sequencer: RTL and testbench

UM245R_SEQUENCER -- requirements
Module: um245r_sequencer

---
 rtl/um245r_sequencer.sv | 165 ++++++++++++++++
 tb/tb_um245r_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/um245r_sequencer.sv
// CPU-side byte FIFOs sequenced onto an FTDI UM245R parallel FIFO port.
// TX bytes go out on WR strobes; RX bytes come in on _RD strobes, shared bus arbitrated round-robin.
module um245r_sequencer #(
  parameter int DEPTH           = 4,
  parameter int STROBE_CYCLES   = 2,
  parameter int RECOVERY_CYCLES = 3
) (
  input  logic       clk,
  input  logic       MR,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       _flag_do,
  output logic       _flag_di,
  input  logic       _TXE,
  input  logic       _RXF,
  output logic       WR,
  output logic       _RD,
  output logic [7:0] dout,
  output logic       dout_oe,
  input  logic [7:0] din
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STROBE_CYCLES + RECOVERY_CYCLES);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, WR_SETUP, WR_STROBE, RD_STROBE, RECOVER} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_tx;
  logic          txe_meta, txe_s, rxf_meta, rxf_s;

  logic [7:0]  tx_mem [DEPTH];
  logic [7:0]  rx_mem [DEPTH];
  logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [AW:0]   tx_count, rx_count;

  logic tx_push, tx_pop, rx_push, rx_pop;
  logic strobe_done, recover_done, tx_elig, rx_elig;

  assign tx_ready = (tx_count != FULL);
  assign rx_valid = (rx_count != '0);
  assign rx_data  = rx_valid ? rx_mem[rx_rd] : 8'h00;
  assign _flag_do = !tx_ready;
  assign _flag_di = !rx_valid;

  assign strobe_done  = (cnt == CW'(STROBE_CYCLES - 1));
  assign recover_done = (cnt == CW'(RECOVERY_CYCLES - 1));
  assign tx_elig      = (tx_count != '0) && !txe_s;
  assign rx_elig      = (rx_count != FULL) && !rxf_s;

  assign tx_push = tx_valid && tx_ready;
  assign tx_pop  = (state == WR_STROBE) && strobe_done;
  assign rx_push = (state == RD_STROBE) && strobe_done;
  assign rx_pop  = rx_valid && rx_ready;

  // Device flags are asynchronous; reset to 1 so nothing is served until they settle.
  always_ff @(posedge clk) begin
    if (MR) begin
      {txe_meta, txe_s, rxf_meta, rxf_s} <= '1;
    end else begin
      txe_meta <= _TXE;
      txe_s    <= txe_meta;
      rxf_meta <= _RXF;
      rxf_s    <= rxf_meta;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: storage arrays carry no reset; the counts alone decide which entries are valid.
    if (tx_push) tx_mem[tx_wr] <= tx_data;
    if (rx_push) rx_mem[rx_wr] <= din;
  end

  always_ff @(posedge clk) begin
    if (MR) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + AW'(1);
      if (tx_pop)  tx_rd <= tx_rd + AW'(1);
      if (rx_push) rx_wr <= rx_wr + AW'(1);
      if (rx_pop)  rx_rd <= rx_rd + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + (AW+1)'(1);
        2'b01:   tx_count <= tx_count - (AW+1)'(1);
        default: ;
      endcase
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + (AW+1)'(1);
        2'b01:   rx_count <= rx_count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Bus sequencer; last_tx = 1 means TX won the last grant, so RX wins the next tie.
  always_ff @(posedge clk) begin
    if (MR) begin
      state   <= IDLE;
      cnt     <= '0;
      last_tx <= 1'b1;
      WR      <= 1'b0;
      _RD     <= 1'b1;
      dout    <= 8'h00;
      dout_oe <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tx_elig && (!rx_elig || !last_tx)) begin
            state   <= WR_SETUP;
            dout    <= tx_mem[tx_rd];
            dout_oe <= 1'b1;
            last_tx <= 1'b1;
          end else if (rx_elig) begin
            state   <= RD_STROBE;
            _RD     <= 1'b0;
            cnt     <= '0;
            last_tx <= 1'b0;
          end
        end
        WR_SETUP: begin
          state <= WR_STROBE;
          WR    <= 1'b1;
          cnt   <= '0;
        end
        WR_STROBE: begin
          if (strobe_done) begin
            state <= RECOVER;
            WR    <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RD_STROBE: begin
          if (strobe_done) begin
            state <= RECOVER;
            _RD   <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RECOVER: begin
          // The 74245 keeps driving D for one cycle past the falling WR edge for hold time.
          dout_oe <= 1'b0;
          if (recover_done) state <= IDLE;
          else              cnt   <= cnt + CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_um245r_sequencer.sv
// Self-checking bench: a transaction-timeline model compared every cycle, plus directed scenarios.
module tb_um245r_sequencer;

  localparam int DEPTH = 4;
  localparam int S     = 2;
  localparam int R     = 3;

  logic       clk = 1'b0;
  logic       mr = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       flag_do, flag_di;
  logic       txe_n = 1'b1;
  logic       rxf_n = 1'b1;
  logic       wr, rd_n;
  logic [7:0] dout;
  logic       dout_oe;
  logic [7:0] din = 8'h00;

  always #5 clk = ~clk;

  um245r_sequencer #(.DEPTH(DEPTH), .STROBE_CYCLES(S), .RECOVERY_CYCLES(R)) dut (
    .clk(clk), .MR(mr),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    ._flag_do(flag_do), ._flag_di(flag_di),
    ._TXE(txe_n), ._RXF(rxf_n),
    .WR(wr), ._RD(rd_n), .dout(dout), .dout_oe(dout_oe), .din(din)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: byte queues plus "which transaction, how many edges since it started".
  typedef enum {K_NONE, K_WR, K_RD} kind_t;
  byte unsigned m_tx[$];
  byte unsigned m_rx[$];
  logic  m_txe1 = 1'b1, m_txe_s = 1'b1, m_rxf1 = 1'b1, m_rxf_s = 1'b1;
  logic  m_last_tx = 1'b1;
  kind_t m_kind = K_NONE;
  int    m_k = 0;
  logic [7:0] m_dout = 8'h00;
  bit    m_live = 1'b0;
  int    m_ntx, m_nrx;
  bit    m_tx_el, m_rx_el, m_rx_in;

  always @(posedge clk) begin
    if (mr) begin
      m_tx.delete();
      m_rx.delete();
      {m_txe1, m_txe_s, m_rxf1, m_rxf_s} = 4'hF;
      m_last_tx = 1'b1;
      m_kind = K_NONE;
      m_k = 0;
      m_dout = 8'h00;
      m_live = 1'b1;
    end else begin
      m_ntx = m_tx.size();
      m_nrx = m_rx.size();
      m_tx_el = (m_ntx > 0) && !m_txe_s;
      m_rx_el = (m_nrx < DEPTH) && !m_rxf_s;
      m_rx_in = 1'b0;
      if (m_kind != K_NONE) begin
        m_k++;
        if (m_kind == K_WR && m_k == S + 1) void'(m_tx.pop_front());
        if (m_kind == K_RD && m_k == S) m_rx_in = 1'b1;
        if ((m_kind == K_WR && m_k == S + 1 + R) || (m_kind == K_RD && m_k == S + R))
          m_kind = K_NONE;
      end else if (m_tx_el && (!m_rx_el || !m_last_tx)) begin
        m_kind = K_WR; m_k = 0; m_dout = m_tx[0]; m_last_tx = 1'b1;
      end else if (m_rx_el) begin
        m_kind = K_RD; m_k = 0; m_last_tx = 1'b0;
      end
      if (tx_valid && m_ntx < DEPTH) m_tx.push_back(tx_data);
      if (rx_ready && m_nrx > 0) void'(m_rx.pop_front());
      if (m_rx_in) m_rx.push_back(din);
      m_txe_s = m_txe1; m_txe1 = txe_n;
      m_rxf_s = m_rxf1; m_rxf1 = rxf_n;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("wr",       wr,       m_kind == K_WR && m_k >= 1 && m_k <= S);
      check("rd_n",     rd_n,     !(m_kind == K_RD && m_k <= S - 1));
      check("dout_oe",  dout_oe,  m_kind == K_WR && m_k <= S + 1);
      check("dout",     dout,     m_dout);
      check("tx_ready", tx_ready, m_tx.size() != DEPTH);
      check("rx_valid", rx_valid, m_rx.size() != 0);
      check("rx_data",  rx_data,  (m_rx.size() != 0) ? m_rx[0] : 8'h00);
      check("flag_do",  flag_do,  m_tx.size() == DEPTH);
      check("flag_di",  flag_di,  m_rx.size() == 0);
      check("bus_excl", !(wr && !rd_n) && !(dout_oe && !rd_n), 1'b1);
    end
  end

  // Bus monitor: logs WR pulses, strobe order and _RD pulse widths.
  int           cyc = 0;
  logic         prev_wr = 1'b0, prev_rd = 1'b1;
  byte unsigned wr_log[$];
  int           wr_cyc[$];
  int           order_log[$];
  int           rd_len[$];
  int           rd_cur = 0;
  int           rd_pulses = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr && !prev_wr) begin
      wr_log.push_back(dout);
      wr_cyc.push_back(cyc);
      order_log.push_back(1);
    end
    if (!rd_n && prev_rd) begin
      order_log.push_back(0);
      rd_cur = 0;
    end
    if (!rd_n) rd_cur++;
    if (rd_n && !prev_rd) begin
      rd_len.push_back(rd_cur);
      rd_pulses++;
    end
    prev_wr = wr;
    prev_rd = rd_n;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    mr = 1'b1; tx_valid = 1'b0; rx_ready = 1'b0;
    tick(2);
    mr = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    tx_data = b; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  byte unsigned rx_got[$];
  int  sent;
  bit  seen;
  logic acc_tx, acc_rx;
  logic [7:0] got_byte;

  initial begin
    // Reset values.
    tick(2);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data",  rx_data,  8'h00);
    check("rst_flag_do",  flag_do,  1'b0);
    check("rst_flag_di",  flag_di,  1'b1);
    check("rst_wr",       wr,       1'b0);
    check("rst_rd_n",     rd_n,     1'b1);
    check("rst_oe",       dout_oe,  1'b0);
    check("rst_dout",     dout,     8'h00);
    mr = 1'b0;

    // Single write, edge-exact timeline.
    txe_n = 1'b0;
    tick(3);
    push(8'hA5);
    check("t1_oe_e0", dout_oe, 1'b0);
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("t1_oe_e%0d", e), dout_oe, (e <= 4));
      check($sformatf("t1_wr_e%0d", e), wr, (e == 2 || e == 3));
      if (e <= 4) check($sformatf("t1_dout_e%0d", e), dout, 8'hA5);
    end

    // Fill while device busy, then drain in order.
    do_reset();
    txe_n = 1'b1;
    tick(2);
    for (int i = 1; i <= 4; i++) push(8'(i));
    check("t2_full_ready", tx_ready, 1'b0);
    check("t2_full_flag",  flag_do,  1'b1);
    push(8'hFF);
    wr_log.delete(); wr_cyc.delete();
    tick(5);
    check("t2_no_wr", wr_log.size(), 0);
    txe_n = 1'b0;
    tick(45);
    check("t2_wr_count", wr_log.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t2_byte%0d", i), (wr_log.size() > i) ? wr_log[i] : 8'hEE, 8'(i + 1));
    for (int i = 1; i < wr_cyc.size(); i++)
      check($sformatf("t2_gap%0d", i), (wr_cyc[i] - wr_cyc[i-1]) >= 7, 1'b1);

    // RX fill with CPU stalled.
    txe_n = 1'b1;
    do_reset();
    rxf_n = 1'b0; din = 8'h3C;
    rd_len.delete(); rd_pulses = 0;
    tick(40);
    check("t3_rd_pulses", rd_pulses, 4);
    for (int i = 0; i < rd_len.size(); i++) check($sformatf("t3_rd_len%0d", i), rd_len[i], S);
    check("t3_rx_valid", rx_valid, 1'b1);
    check("t3_rx_data",  rx_data,  8'h3C);
    check("t3_flag_di",  flag_di,  1'b0);
    check("t3_rd_idle",  rd_n,     1'b1);

    // Round-robin tie: RX wins first.
    rxf_n = 1'b1;
    do_reset();
    push(8'hAA);
    push(8'hBB);
    order_log.delete();
    txe_n = 1'b0; rxf_n = 1'b0;
    tick(30);
    for (int i = 0; i < 4; i++)
      check($sformatf("t4_order%0d", i), (order_log.size() > i) ? order_log[i] : 9, (i % 2));

    // Random-handshake streaming through both FIFOs.
    txe_n = 1'b1; rxf_n = 1'b1;
    do_reset();
    wr_log.delete(); rx_got.delete();
    rd_pulses = 0; sent = 0;
    txe_n = 1'b0; rxf_n = 1'b0;
    for (int c = 0; c < 800 && !(sent == 10 && wr_log.size() >= 10 && rx_got.size() >= 10); c++) begin
      tx_valid = (sent < 10) && ($urandom_range(0, 1) == 1);
      tx_data  = 8'(8'h10 + sent);
      rx_ready = ($urandom_range(0, 2) != 0);
      din      = 8'(8'h80 + rd_pulses);
      #1;
      acc_tx = tx_valid && tx_ready;
      acc_rx = rx_ready && rx_valid;
      got_byte = rx_data;
      tick();
      if (acc_tx) sent++;
      if (acc_rx) rx_got.push_back(got_byte);
    end
    tx_valid = 1'b0; rx_ready = 1'b0;
    check("t5_sent",   sent, 10);
    check("t5_wr_cnt", wr_log.size() >= 10, 1'b1);
    check("t5_rx_cnt", rx_got.size() >= 10, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t5_tx%0d", i), (wr_log.size() > i) ? wr_log[i] : 8'hEE, 8'(8'h10 + i));
      check($sformatf("t5_rx%0d", i), (rx_got.size() > i) ? rx_got[i] : 8'hEE, 8'(8'h80 + i));
    end

    // Reset in the middle of a write strobe.
    rxf_n = 1'b1; txe_n = 1'b1;
    do_reset();
    tick(2);
    push(8'h51); push(8'h52); push(8'h53);
    txe_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (wr) seen = 1'b1;
      else    tick();
    end
    check("t6_wr_seen", seen, 1'b1);
    mr = 1'b1;
    tick();
    mr = 1'b0;
    check("t6_wr",       wr,       1'b0);
    check("t6_oe",       dout_oe,  1'b0);
    check("t6_tx_ready", tx_ready, 1'b1);
    check("t6_flag_di",  flag_di,  1'b1);
    wr_log.delete();
    tick(30);
    check("t6_no_wr", wr_log.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
